// File: rtl/memory_responder_if.sv
// Memory port bundle between the multi-cycle core and its memory responder.
// The core drives requests as master; the responder answers as slave.
interface memory_responder_if;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        memory_ready;
    logic        bus_error;

    modport master (
        output memory_read, memory_write, address, write_data,
        input  read_data, memory_ready, bus_error
    );

    modport slave (
        input  memory_read, memory_write, address, write_data,
        output read_data, memory_ready, bus_error
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM plus one MMIO LED register behind the core memory port,
// with programmable wait states and a one-cycle ready pulse.
module memory_responder #(
    parameter int          DEPTH         = 1024,
    parameter int          WAIT_CYCLES   = 1,
    parameter logic [31:0] MMIO_LED_ADDR = 32'h8000_0000,
    parameter int          LED_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_responder_if.slave    bus,
    output logic [LED_WIDTH-1:0] leds
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          addr_q, wdata_q;
    logic                 rd_q, wr_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ready_q, err_q;
    logic [LED_WIDTH-1:0] leds_q;

    logic [31:0] mem [DEPTH];

    logic        accept, access;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_rd, acc_wr;
    logic        in_ram, is_led, err;
    logic        ram_we, led_we;
    logic [AW-1:0] idx;

    assign accept = (state_q == S_IDLE) &&
                    (bus.memory_read || bus.memory_write);

    // With no wait states the accept edge is also the access edge.
    assign access = (accept && WAIT_CYCLES == 0) ||
                    (state_q == S_WAIT && cnt_q == 4'd1);

    assign acc_addr  = accept ? bus.address      : addr_q;
    assign acc_wdata = accept ? bus.write_data   : wdata_q;
    assign acc_rd    = accept ? bus.memory_read  : rd_q;
    assign acc_wr    = accept ? bus.memory_write : wr_q;

    assign idx    = acc_addr[AW+1:2];
    assign in_ram = {1'b0, acc_addr} < RAM_BYTES;
    assign is_led = acc_addr == MMIO_LED_ADDR;
    assign err    = (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr) ||
                    !(in_ram || is_led);

    assign ram_we = access && acc_wr && !err && in_ram;
    assign led_we = access && acc_wr && !err && is_led;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept)
                        state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = WAIT_INIT;
        else if (state_q == S_WAIT)
            cnt_d = cnt_q - 4'd1;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (access) begin
            if (err || acc_wr)
                rdata_d = 32'd0;
            else if (in_ram)
                rdata_d = mem[idx];
            else
                rdata_d = {{(32-LED_WIDTH){1'b0}}, leds_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= access;
            err_q   <= access && err;
            if (accept) begin
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
                rd_q    <= bus.memory_read;
                wr_q    <= bus.memory_write;
            end
            if (led_we)
                leds_q <= acc_wdata[LED_WIDTH-1:0];
        end
    end

    // Storage is not reset; reset only blocks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (ram_we && !reset)
            mem[idx] <= acc_wdata;
    end

    assign bus.read_data    = rdata_q;
    assign bus.memory_ready = ready_q;
    assign bus.bus_error    = err_q;
    assign leds             = leds_q;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: vector table with a response scoreboard,
// plus hand sequences for reset, zero-wait and aborted requests.
module tb_memory_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_responder_if bus ();
    memory_responder_if bus0 ();
    logic [7:0] leds, leds0;

    memory_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .leds(leds)
    );
    memory_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .leds(leds0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_leds;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [31:0] LED = 32'h8000_0000;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic txn(input string name, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input exp_t e, input int exp_lat);
        int   lat;
        exp_t got;
        @(negedge clk);
        bus.memory_read  = rd;
        bus.memory_write = wr;
        bus.address      = a;
        bus.write_data   = wd;
        sbq.push_back(e);
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.memory_ready) begin
                lat = i;
                break;
            end
        end
        bus.memory_read  = 1'b0;
        bus.memory_write = 1'b0;
        got = sbq.pop_front();
        if (lat == 0) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " rdata"}, bus.read_data, got.rdata);
            check({name, " err"}, {31'd0, bus.bus_error}, {31'd0, got.err});
        end
        @(negedge clk);
        check({name, " pulse"}, {31'd0, bus.memory_ready}, 32'd0);
    endtask

    vec_t vecs[14];
    logic [3:0] pat;

    initial begin
        bus.memory_read   = 1'b0;
        bus.memory_write  = 1'b0;
        bus.address       = 32'd0;
        bus.write_data    = 32'd0;
        bus0.memory_read  = 1'b0;
        bus0.memory_write = 1'b0;
        bus0.address      = 32'd0;
        bus0.write_data   = 32'd0;

        vecs[0]  = '{0, 1, 32'h10,   32'hDEADBEEF, 32'h0,        0, 8'h00};
        vecs[1]  = '{1, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 8'h00};
        vecs[2]  = '{0, 1, LED,      32'h1A5,      32'h0,        0, 8'hA5};
        vecs[3]  = '{1, 0, LED,      32'h0,        32'h000000A5, 0, 8'hA5};
        vecs[4]  = '{1, 0, 32'h12,   32'h0,        32'h0,        1, 8'hA5};
        vecs[5]  = '{0, 1, 32'h4000, 32'h5555AAAA, 32'h0,        1, 8'hA5};
        vecs[6]  = '{1, 1, 32'h10,   32'h0BADF00D, 32'h0,        1, 8'hA5};
        vecs[7]  = '{1, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 8'hA5};
        vecs[8]  = '{0, 1, 32'hFFC,  32'h12345678, 32'h0,        0, 8'hA5};
        vecs[9]  = '{1, 0, 32'hFFC,  32'h0,        32'h12345678, 0, 8'hA5};
        vecs[10] = '{0, 1, 32'h1000, 32'h77777777, 32'h0,        1, 8'hA5};
        vecs[11] = '{0, 1, 32'h0,    32'hCAFEF00D, 32'h0,        0, 8'hA5};
        vecs[12] = '{1, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0, 8'hA5};
        vecs[13] = '{0, 1, 32'h20,   32'h11112222, 32'h0,        0, 8'hA5};

        reset = 1'b1;
        #12;
        check("rst rdata", bus.read_data, 32'd0);
        check("rst ready", {31'd0, bus.memory_ready}, 32'd0);
        check("rst err", {31'd0, bus.bus_error}, 32'd0);
        check("rst leds", {24'd0, leds}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            exp_t e;
            e.rdata = vecs[i].exp_rdata;
            e.err   = vecs[i].exp_err;
            txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr,
                vecs[i].addr, vecs[i].wdata, e, 2);
            check($sformatf("vec%0d leds", i), {24'd0, leds},
                  {24'd0, vecs[i].exp_leds});
        end

        // zero-wait instance: a held read is re-accepted every other cycle
        @(negedge clk);
        bus0.address     = 32'h0;
        bus0.memory_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = bus0.memory_ready;
            if (i == 2) bus0.memory_read = 1'b0;
        end
        check("w0 pulses", {28'd0, pat}, 32'h5);
        check("w0 err", {31'd0, bus0.bus_error}, 32'd0);

        // write aborted by reset during WAIT
        @(negedge clk);
        bus.address      = 32'h20;
        bus.write_data   = 32'h99999999;
        bus.memory_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset            = 1'b1;
        bus.memory_write = 1'b0;
        pat = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pat[i] = bus.memory_ready;
        end
        check("abort ready", {28'd0, pat}, 32'd0);
        reset = 1'b0;
        begin
            exp_t e;
            e.rdata = 32'h11112222;
            e.err   = 1'b0;
            txn("abort rd", 1'b1, 1'b0, 32'h20, 32'h0, e, 2);
        end

        // set the LEDs again, then reset asynchronously while ready is high
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            txn("led2", 1'b0, 1'b1, LED, 32'h3C, e, 2);
        end
        check("led2 leds", {24'd0, leds}, 32'h3C);
        @(negedge clk);
        bus.address     = 32'h10;
        bus.memory_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid ready", {31'd0, bus.memory_ready}, 32'd1);
        check("mid rdata", bus.read_data, 32'hDEADBEEF);
        #1 reset = 1'b1;
        #1;
        check("async ready", {31'd0, bus.memory_ready}, 32'd0);
        check("async rdata", bus.read_data, 32'd0);
        check("async err", {31'd0, bus.bus_error}, 32'd0);
        check("async leds", {24'd0, leds}, 32'd0);
        bus.memory_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        begin
            exp_t e;
            e.rdata = 32'hDEADBEEF;
            e.err   = 1'b0;
            txn("post rst", 1'b1, 1'b0, 32'h10, 32'h0, e, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
